i2s_dac_tx: RTL and testbench

Transmit side of the audio CODEC serial link. Accepts a stereo sample pair through a write/write_ready handshake, the same handshake the FIR output and CODEC write port use. Serialises the pair onto the DAC data line in I2S format, slaved to the CODEC-driven bit clock and DAC LR clock. Sits between the filter/loopback datapath and the AUD_DACDAT pin, which allows the packaged CODEC write path to be bypassed.

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_dac_tx_sync_edge.sv | 35 +++
 rtl/i2s_dac_tx.sv | 146 ++++++++++++++
 tb/tb_i2s_dac_tx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared defaults and types for the I2S DAC transmitter
package i2s_pkg;
   localparam int DEF_DATA_W = 24;
   localparam int DEF_SLOT_W = 32;
   localparam int CNT_W      = $clog2(DEF_DATA_W + 1);

   typedef logic signed [DEF_DATA_W-1:0] sample_t;

   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } chan_e;
endpackage

// File: rtl/i2s_dac_tx_sync_edge.sv
// rtl/i2s_dac_tx_sync_edge.sv - 2-FF synchroniser with registered level and edge pulses
module sync_edge (
   input  logic ck,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);
   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic last_q, last_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
      last_d = sync_q;
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         last_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         last_q <= last_d;
      end
   end

   assign level = sync_q;
   assign rise  = sync_q & ~last_q;
   assign fall  = ~sync_q & last_q;
endmodule

// File: rtl/i2s_dac_tx.sv
// rtl/i2s_dac_tx.sv - I2S serialiser for the DAC data line, slaved to CODEC BCLK/LRCK
module i2s_dac_tx
   import i2s_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int SLOT_W = DEF_SLOT_W
) (
   input  logic              ck,
   input  logic              rst,
   input  logic              write,
   input  logic [DATA_W-1:0] writedata_left,
   input  logic [DATA_W-1:0] writedata_right,
   output logic              write_ready,
   input  logic              aud_bclk,
   input  logic              aud_daclrck,
   output logic              aud_dacdat,
   output logic              underrun
);
   localparam int BIT_CNT_W = $clog2(DATA_W + 1);
   // Never serialise past the end of a slot, even if the slot is configured too short.
   localparam int LAST_BIT = (DATA_W < SLOT_W) ? DATA_W : SLOT_W - 1;
   localparam logic [BIT_CNT_W-1:0] LAST_CNT = BIT_CNT_W'(LAST_BIT);

   logic bclk_fall, lrck_lvl;
   logic unused_bclk_lvl, unused_bclk_rise, unused_lrck_rise, unused_lrck_fall;

   sync_edge u_bclk_sync (
      .ck    (ck),
      .rst   (rst),
      .din   (aud_bclk),
      .level (unused_bclk_lvl),
      .rise  (unused_bclk_rise),
      .fall  (bclk_fall)
   );

   sync_edge u_lrck_sync (
      .ck    (ck),
      .rst   (rst),
      .din   (aud_daclrck),
      .level (lrck_lvl),
      .rise  (unused_lrck_rise),
      .fall  (unused_lrck_fall)
   );

   logic [DATA_W-1:0]    hold_left_q, hold_left_d;
   logic [DATA_W-1:0]    hold_right_q, hold_right_d;
   logic                 hold_valid_q, hold_valid_d;
   logic [DATA_W-1:0]    shifter_q, shifter_d;
   logic [DATA_W-1:0]    right_active_q, right_active_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                 armed_q, armed_d;
   chan_e                lr_prev_q, lr_prev_d;
   logic                 dacdat_q, dacdat_d;
   logic                 underrun_q, underrun_d;
   logic                 write_ready_q, write_ready_d;

   chan_e lr_chan;
   logic  slot_left, slot_right;

   assign lr_chan    = chan_e'(lrck_lvl);
   assign slot_left  = (lr_prev_q == CH_RIGHT) && (lr_chan == CH_LEFT);
   assign slot_right = (lr_prev_q == CH_LEFT) && (lr_chan == CH_RIGHT);

   always_comb begin
      hold_left_d    = hold_left_q;
      hold_right_d   = hold_right_q;
      hold_valid_d   = hold_valid_q;
      shifter_d      = shifter_q;
      right_active_d = right_active_q;
      bit_cnt_d      = bit_cnt_q;
      armed_d        = armed_q;
      lr_prev_d      = lr_prev_q;
      dacdat_d       = dacdat_q;
      underrun_d     = 1'b0;

      // write_ready is low whenever a left-slot transfer could clear hold_valid, so no overlap.
      if (write && write_ready_q) begin
         hold_left_d  = writedata_left;
         hold_right_d = writedata_right;
         hold_valid_d = 1'b1;
      end

      if (bclk_fall) begin
         lr_prev_d = lr_chan;
         dacdat_d  = 1'b0;
         if (slot_left) begin
            if (hold_valid_q) begin
               shifter_d      = hold_left_q;
               right_active_d = hold_right_q;
               hold_valid_d   = 1'b0;
            end else begin
               shifter_d      = '0;
               right_active_d = '0;
               underrun_d     = 1'b1;
            end
            armed_d   = 1'b1;
            bit_cnt_d = '0;
         end else if (slot_right) begin
            shifter_d = right_active_q;
            armed_d   = 1'b1;
            bit_cnt_d = '0;
         end else if (armed_q) begin
            dacdat_d  = shifter_q[DATA_W-1];
            shifter_d = {shifter_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            if (bit_cnt_d == LAST_CNT) begin
               armed_d = 1'b0;
            end
         end
      end

      write_ready_d = ~hold_valid_d;
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         hold_left_q    <= '0;
         hold_right_q   <= '0;
         hold_valid_q   <= 1'b0;
         shifter_q      <= '0;
         right_active_q <= '0;
         bit_cnt_q      <= '0;
         armed_q        <= 1'b0;
         lr_prev_q      <= CH_RIGHT;
         dacdat_q       <= 1'b0;
         underrun_q     <= 1'b0;
         write_ready_q  <= 1'b1;
      end else begin
         hold_left_q    <= hold_left_d;
         hold_right_q   <= hold_right_d;
         hold_valid_q   <= hold_valid_d;
         shifter_q      <= shifter_d;
         right_active_q <= right_active_d;
         bit_cnt_q      <= bit_cnt_d;
         armed_q        <= armed_d;
         lr_prev_q      <= lr_prev_d;
         dacdat_q       <= dacdat_d;
         underrun_q     <= underrun_d;
         write_ready_q  <= write_ready_d;
      end
   end

   assign write_ready = write_ready_q;
   assign aud_dacdat  = dacdat_q;
   assign underrun    = underrun_q;
endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb/tb_i2s_dac_tx.sv - directed bench for i2s_dac_tx, 32-ck BCLK, 32-bit slots
module tb_i2s_dac_tx;
   logic        ck = 1'b0;
   logic        rst;
   logic        write;
   logic [23:0] wdata_l, wdata_r;
   logic        write_ready;
   logic        bclk, lrck;
   logic        aud_dacdat;
   logic        underrun;

   i2s_dac_tx dut (
      .ck              (ck),
      .rst             (rst),
      .write           (write),
      .writedata_left  (wdata_l),
      .writedata_right (wdata_r),
      .write_ready     (write_ready),
      .aud_bclk        (bclk),
      .aud_daclrck     (lrck),
      .aud_dacdat      (aud_dacdat),
      .underrun        (underrun)
   );

   always #5 ck = ~ck;

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      logic [31:0] el;
      logic [31:0] er;
   } vec_t;

   vec_t        vecs [0:14];
   logic [31:0] exp_word [0:63];
   bit          exp_vld [0:63];
   int          n_checks = 0;
   int          n_fail = 0;
   int          slot_idx = 0;
   int          rises = 0;
   int          und_cnt = 0;
   int          cyc = 0;
   int          fall_cyc = 0;
   bit          gen_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic wait_slots(input int n);
      int t = 0;
      while (slot_idx < n && t < 8000) begin
         @(negedge ck);
         t++;
      end
      if (slot_idx < n) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_slots: reached slot %0d, want %0d", slot_idx, n);
      end
   endtask

   task automatic wait_ready(input logic val);
      int t = 0;
      while (write_ready !== val && t < 3000) begin
         @(negedge ck);
         t++;
      end
      if (write_ready !== val) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_ready: got %b, want %b", write_ready, val);
      end
   endtask

   task automatic do_write(input logic [23:0] l, input logic [23:0] r);
      write   = 1'b1;
      wdata_l = l;
      wdata_r = r;
      @(negedge ck);
      write   = 1'b0;
   endtask

   task automatic expect_vec(input int slot, input int k);
      exp_word[slot]   = vecs[k].el;
      exp_vld[slot]    = 1'b1;
      exp_word[slot+1] = vecs[k].er;
      exp_vld[slot+1]  = 1'b1;
   endtask

   task automatic expect_zero(input int slot);
      exp_word[slot] = 32'h0;
      exp_vld[slot]  = 1'b1;
   endtask

   always @(posedge ck) cyc++;

   always @(negedge ck) begin
      if (underrun === 1'b1) und_cnt++;
   end

   // BCLK/LRCK generator; samples DAC data at each BCLK rise, as the CODEC would.
   initial begin
      logic [31:0] cur;
      bclk = 1'b1;
      lrck = 1'b1;
      wait (gen_en);
      forever begin
         for (int ch = 0; ch < 2; ch++) begin
            cur = '0;
            for (int b = 0; b < 32; b++) begin
               repeat (16) @(negedge ck);
               bclk = 1'b0;
               if (b == 0) begin
                  lrck = ch[0];
                  if (ch == 0) fall_cyc = cyc;
               end
               repeat (16) @(negedge ck);
               cur  = {cur[30:0], aud_dacdat};
               bclk = 1'b1;
               rises = b + 1;
            end
            if (exp_vld[slot_idx]) check($sformatf("slot%0d", slot_idx), cur, exp_word[slot_idx]);
            slot_idx++;
            rises = 0;
         end
      end
   end

   initial begin
      int und_base;
      int t;
      for (int i = 0; i < 64; i++) begin
         exp_vld[i]  = 1'b0;
         exp_word[i] = '0;
      end
      vecs[0]  = '{24'hA5A5A5, 24'h3C3C3C, 32'h52D2D280, 32'h1E1E1E00};
      vecs[1]  = '{24'h123456, 24'hABCDEF, 32'h091A2B00, 32'h55E6F780};
      vecs[2]  = '{24'h555555, 24'hAAAAAA, 32'h2AAAAA80, 32'h55555500};
      vecs[3]  = '{24'h0F0F0F, 24'hF0F0F0, 32'h07878780, 32'h78787800};
      vecs[4]  = '{24'h000001, 24'h800000, 32'h00000080, 32'h40000000};
      vecs[5]  = '{24'hFFFFFF, 24'h7FFFFF, 32'h7FFFFF80, 32'h3FFFFF80};
      vecs[6]  = '{24'h555555, 24'hAAAAAA, 32'h2AAAAA80, 32'h55555500};
      vecs[7]  = '{24'hC00003, 24'h00FF00, 32'h60000180, 32'h007F8000};
      vecs[8]  = '{24'h654321, 24'h000000, 32'h32A19080, 32'h00000000};
      vecs[9]  = '{24'h7FFFFF, 24'h000001, 32'h3FFFFF80, 32'h00000080};
      vecs[10] = '{24'hAAAAAA, 24'hC00003, 32'h55555500, 32'h60000180};
      vecs[11] = '{24'h00FF00, 24'h654321, 32'h007F8000, 32'h32A19080};
      vecs[12] = '{24'hFFFFFF, 24'hFFFFFF, 32'h7FFFFF80, 32'h7FFFFF80};
      vecs[13] = '{24'h654321, 24'h123456, 32'h32A19080, 32'h091A2B00};
      vecs[14] = '{24'h800000, 24'hFFFFFF, 32'h40000000, 32'h7FFFFF80};

      rst     = 1'b1;
      write   = 1'b0;
      wdata_l = '0;
      wdata_r = '0;
      repeat (4) @(negedge ck);
      check("rst_write_ready", write_ready, 1);
      check("rst_dacdat", aud_dacdat, 0);
      check("rst_underrun", underrun, 0);
      rst = 1'b0;
      repeat (4) @(negedge ck);

      // Test 1: pair written before the first left slot.
      expect_vec(0, 0);
      do_write(vecs[0].l, vecs[0].r);
      check("t1_ready_drop", write_ready, 0);
      und_base = und_cnt;
      gen_en = 1'b1;
      wait_slots(2);
      check("t1_underrun", und_cnt - und_base, 0);
      check("t1_ready_back", write_ready, 1);

      // Test 2: no write, so frame 1 underruns once and sends zeros.
      expect_zero(2);
      expect_zero(3);
      und_base = und_cnt;
      wait_slots(4);
      check("t2_underrun_cycles", und_cnt - und_base, 1);
      check("t2_ready", write_ready, 1);

      // Test 3: P2 while full is dropped; P3 after the transfer lands in the next frame.
      expect_vec(4, 1);
      expect_vec(6, 3);
      do_write(vecs[1].l, vecs[1].r);
      check("t3_ready_low", write_ready, 0);
      do_write(vecs[2].l, vecs[2].r);
      wait_ready(1'b1);
      check("t3_ready_latency_ok", (cyc - fall_cyc) <= 4, 1);
      @(negedge ck);
      do_write(vecs[3].l, vecs[3].r);
      check("t3_p3_taken", write_ready, 0);
      wait_slots(8);

      // Test 4: eight back-to-back frames, each written one ck after write_ready rises.
      for (int v = 0; v < 8; v++) expect_vec(8 + 2 * v, 4 + v);
      und_base = und_cnt;
      for (int v = 0; v < 8; v++) begin
         if (v > 0) begin
            wait_ready(1'b0);
            wait_ready(1'b1);
            @(negedge ck);
         end
         do_write(vecs[4 + v].l, vecs[4 + v].r);
      end
      wait_slots(24);
      check("t4_underrun", und_cnt - und_base, 0);

      // Test 5: reset after 10 left data bits aborts the word and drops the held pair.
      expect_zero(25);
      expect_zero(26);
      expect_zero(27);
      do_write(vecs[12].l, vecs[12].r);
      wait_ready(1'b0);
      wait_ready(1'b1);
      @(negedge ck);
      do_write(vecs[13].l, vecs[13].r);
      check("t5_held_before_rst", write_ready, 0);
      t = 0;
      while (!(slot_idx == 24 && rises == 11) && t < 3000) begin
         @(negedge ck);
         t++;
      end
      check("t5_mid_word_bit", aud_dacdat, 1);
      rst = 1'b1;
      @(negedge ck);
      check("t5_rst_dacdat", aud_dacdat, 0);
      check("t5_rst_ready", write_ready, 1);
      @(negedge ck);
      rst = 1'b0;
      wait_slots(28);

      // Test 6: negative extremes, no sign extension into the padding bits.
      expect_vec(28, 14);
      do_write(vecs[14].l, vecs[14].r);
      wait_slots(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
